// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush and valid bit.
// Define LOAD_USE_DETECT_EN to build the internal load-use hazard detector.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic [1:0]        id_ALUOp,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemtoReg,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic [1:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              load_use_stall
);
    localparam int W = 10 + 4 * DATA_W + 3 * REG_AW;

    logic [W-1:0] idBus, exBus;
    logic takeId;

    assign idBus = {id_valid, id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite,
                    id_ALUSrc, id_RegWrite, id_ALUOp, id_pc4, id_rd1, id_rd2, id_imm,
                    id_rs, id_rt, id_rd};
    assign {ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
            ex_ALUSrc, ex_RegWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm,
            ex_rs, ex_rt, ex_rd} = exBus;

`ifdef LOAD_USE_DETECT_EN
    // rt only matters as a source when the consumer actually reads it
    assign load_use_stall = id_valid & ex_valid & ex_MemRead & (ex_rt != '0) &
                            ((ex_rt == id_rs) |
                             ((ex_rt == id_rt) & (id_RegDst | id_Branch | id_MemWrite)));
`else
    assign load_use_stall = 1'b0;
`endif

    // any non-loaded slot is an all-zero bubble, so no stray write enables
    assign takeId = id_valid & ~load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exBus <= '0;
        else if (flush)
            exBus <= '0;
        else if (!stall)
            exBus <= takeId ? idBus : '0;
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized check of id_ex_pipe_reg against a behavioural model,
// plus directed sequences with literal expectations.
module tb_id_ex_pipe_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        idValid = 1'b0;
    logic [6:0]  idCtl = '0;
    logic [1:0]  idOp = '0;
    logic [31:0] idPc4 = '0, idRd1 = '0, idRd2 = '0, idImm = '0;
    logic [4:0]  idRs = '0, idRt = '0, idRd = '0;
    logic        exValid, lus;
    logic [6:0]  exCtl;
    logic [1:0]  exOp;
    logic [31:0] exPc4, exRd1, exRd2, exImm;
    logic [4:0]  exRs, exRt, exRd;

    // model of the EX slot; ctl bits: 6 RegDst,5 Branch,4 MemRead,3 MemtoReg,2 MemWrite,1 ALUSrc,0 RegWrite
    logic        mValid;
    logic [6:0]  mCtl;
    logic [1:0]  mOp;
    logic [31:0] mPc4, mRd1, mRd2, mImm;
    logic [4:0]  mRs, mRt, mRd;

    int checks = 0;
    int failures = 0;

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(idValid),
        .id_RegDst(idCtl[6]), .id_Branch(idCtl[5]), .id_MemRead(idCtl[4]),
        .id_MemtoReg(idCtl[3]), .id_MemWrite(idCtl[2]), .id_ALUSrc(idCtl[1]),
        .id_RegWrite(idCtl[0]), .id_ALUOp(idOp), .id_pc4(idPc4), .id_rd1(idRd1),
        .id_rd2(idRd2), .id_imm(idImm), .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
        .ex_valid(exValid),
        .ex_RegDst(exCtl[6]), .ex_Branch(exCtl[5]), .ex_MemRead(exCtl[4]),
        .ex_MemtoReg(exCtl[3]), .ex_MemWrite(exCtl[2]), .ex_ALUSrc(exCtl[1]),
        .ex_RegWrite(exCtl[0]), .ex_ALUOp(exOp), .ex_pc4(exPc4), .ex_rd1(exRd1),
        .ex_rd2(exRd2), .ex_imm(exImm), .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd),
        .load_use_stall(lus)
    );

    always #5 clk = ~clk;

    function automatic logic expLus();
`ifdef LOAD_USE_DETECT_EN
        return idValid && mValid && mCtl[4] && mRt != 0 &&
               (mRt == idRs || (mRt == idRt && (idCtl[6] || idCtl[5] || idCtl[2])));
`else
        return 1'b0;
`endif
    endfunction

    task automatic clearModel();
        {mValid, mCtl, mOp, mPc4, mRd1, mRd2, mImm, mRs, mRt, mRd} = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush)
            clearModel();
        else if (!stall) begin
            if (!idValid || expLus())
                clearModel();
            else begin
                mValid = 1'b1; mCtl = idCtl; mOp = idOp;
                mPc4 = idPc4; mRd1 = idRd1; mRd2 = idRd2; mImm = idImm;
                mRs = idRs; mRt = idRt; mRd = idRd;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", 32'(exValid), 32'(mValid));
        chk("ctl", 32'(exCtl), 32'(mCtl));
        chk("aluop", 32'(exOp), 32'(mOp));
        chk("pc4", exPc4, mPc4);
        chk("rd1", exRd1, mRd1);
        chk("rd2", exRd2, mRd2);
        chk("imm", exImm, mImm);
        chk("idx", {17'd0, exRs, exRt, exRd}, {17'd0, mRs, mRt, mRd});
        chk("lus", 32'(lus), 32'(expLus()));
    end

    task automatic setIn(input logic v, input logic [6:0] c, input logic [1:0] op,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        idValid = v; idCtl = c; idOp = op; idPc4 = 32'h100 + imm;
        idRd1 = rd1; idRd2 = rd2; idImm = imm; idRs = rs; idRt = rt; idRd = rd;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        chk("d_reset_valid", 32'(exValid), 0);
        chk("d_reset_ctl", 32'(exCtl), 0);
        rst_n = 1'b1;
        // R-type: RegDst, RegWrite, ALUOp=10
        setIn(1, 7'b1000001, 2'b10, 32'h5, 32'h3, 32'h0, 5'd1, 5'd2, 5'd8);
        step();
        chk("d_rtype_valid", 32'(exValid), 1);
        chk("d_rtype_ctl", 32'(exCtl), 32'h41);
        chk("d_rtype_op", 32'(exOp), 2);
        chk("d_rtype_rd1", exRd1, 5);
        chk("d_rtype_rd2", exRd2, 3);
        chk("d_rtype_rd", 32'(exRd), 8);
        // lw: MemRead, MemtoReg, ALUSrc, RegWrite
        setIn(1, 7'b0011011, 2'b00, 32'h7, 32'h0, 32'h10, 5'd4, 5'd9, 5'd0);
        step();
        chk("d_lw_ctl", 32'(exCtl), 32'h1b);
        chk("d_lw_imm", exImm, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setIn(1, 7'($urandom), 2'($urandom), $urandom, $urandom, 32'h40 + i, 5'($urandom),
                  5'($urandom), 5'($urandom));
            step();
            chk("d_stall_imm", exImm, 32'h10);
            chk("d_stall_ctl", 32'(exCtl), 32'h1b);
            chk("d_stall_rt", 32'(exRt), 9);
        end
        stall = 1'b0;
        setIn(1, 7'b0000011, 2'b00, 32'h1, 32'h2, 32'h22, 5'd5, 5'd6, 5'd0);
        step();
        chk("d_release_imm", exImm, 32'h22);
        chk("d_release_rt", 32'(exRt), 6);
        // sw under simultaneous stall+flush
        setIn(1, 7'b0000110, 2'b00, 32'h1, 32'h2, 32'h4, 5'd1, 5'd2, 5'd0);
        stall = 1'b1; flush = 1'b1;
        step();
        chk("d_flush_valid", 32'(exValid), 0);
        chk("d_flush_ctl", 32'(exCtl), 0);
        chk("d_flush_imm", exImm, 0);
        stall = 1'b0; flush = 1'b0;
        setIn(0, 7'b0000001, 2'b10, 32'h9, 32'h9, 32'h9, 5'd1, 5'd2, 5'd3);
        step();
        chk("d_bubble_valid", 32'(exValid), 0);
        chk("d_bubble_rw", 32'(exCtl[0]), 0);
        // load-use: lw rt=9 followed by add rs=9
        setIn(1, 7'b0011011, 2'b00, 32'h0, 32'h0, 32'h8, 5'd4, 5'd9, 5'd0);
        step();
        setIn(1, 7'b1000001, 2'b10, 32'h1, 32'h2, 32'h0, 5'd9, 5'd3, 5'd10);
        #1;
`ifdef LOAD_USE_DETECT_EN
        chk("d_lu_stall", 32'(lus), 1);
        step();
        chk("d_lu_bubble", 32'(exValid), 0);
        step();
        chk("d_lu_add_valid", 32'(exValid), 1);
        chk("d_lu_add_rs", 32'(exRs), 9);
`else
        chk("d_lu_off", 32'(lus), 0);
        step();
        chk("d_lu_add_valid", 32'(exValid), 1);
        chk("d_lu_add_rs", 32'(exRs), 9);
`endif
        setIn(1, 7'b0011011, 2'b00, 32'h0, 32'h0, 32'h8, 5'd4, 5'd0, 5'd0);
        step();
        setIn(1, 7'b1000001, 2'b10, 32'h1, 32'h2, 32'h0, 5'd0, 5'd3, 5'd10);
        #1;
        chk("d_lu_rt0", 32'(lus), 0);
        step();
        chk("d_lu_rt0_valid", 32'(exValid), 1);
        // asynchronous reset in mid-cycle
        @(posedge clk);
        #2;
        chk("d_pre_reset_rw", 32'(exCtl[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("d_async_valid", 32'(exValid), 0);
        chk("d_async_ctl", 32'(exCtl), 0);
        chk("d_async_data", exPc4 | exRd1 | exRd2 | exImm, 0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rs, rt;
            rs = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rt = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            setIn(($urandom % 5) != 0, 7'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                  rs, rt, 5'($urandom));
            idPc4 = $urandom;
            if ($urandom % 250 == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register. Sits directly downstream of the decode-stage control unit and register file.
- Captures the decoded control bits, register operands, sign-extended immediate, register indices and PC+4 each cycle, and presents them to the EX stage.
- Supports stall (hold), flush (bubble insert) and a valid bit.
- Optionally contains the load-use hazard detector that inserts bubbles itself.

Parameters:
- DATA_W, 32, width of operands, immediate and PC+4
- REG_AW, 5, register index width

Ports:
- clk  input  1  pipeline clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold current contents (from downstream or hazard unit)
- flush  input  1  replace incoming instruction with bubble (branch taken / exception)
- id_valid  input  1  decode slot holds a real instruction
- id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  input  1 each  decoded control bits
- id_ALUOp  input  2  decoded ALU op class
- id_pc4  input  DATA_W  PC+4 of decode instruction
- id_rd1, id_rd2  input  DATA_W  register-file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_AW  register indices
- ex_valid  output  1  EX slot holds a real instruction
- ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  output  1 each  registered control bits
- ex_ALUOp  output  2  registered ALU op class
- ex_pc4, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered indices
- load_use_stall  output  1  combinational; only driven when LOAD_USE_DETECT_EN is defined, else tied 0

Behaviour:
- Reset: rst_n low asynchronously clears every output register to 0, including ex_valid and ex_ALUOp = 2'b00. Reset mid-stall or mid-flush wins unconditionally.
- Latency: 1 cycle. Values on id_* at rising edge N appear on ex_* after edge N.
- Per-edge priority is flush > stall > internal bubble (feature only) > load.
- flush=1 (with or without stall): ex_valid and all control bits go to 0, ex_ALUOp to 00. Data and index fields load 0.
- stall=1, flush=0: every ex_* register holds its value.
- Load with id_valid=0: load a bubble, i.e. controls and valid 0, data fields 0.
- Load with id_valid=1: load all id_* fields; ex_valid=1.
- A bubble must never carry RegWrite, MemWrite, MemRead or Branch = 1.
- No internal state beyond the registers; no wrap or overflow concerns.

Optional Feature:
- Macro: LOAD_USE_DETECT_EN.
- Defined: load_use_stall = id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & (id_RegDst | id_Branch | id_MemWrite))).
  - When load_use_stall=1 and flush=0 and stall=0: the block loads a bubble on the edge.
  - Upstream must use load_use_stall to hold PC and IF/ID, so the dependent instruction re-presents on the next cycle and then loads normally.
  - External stall still holds the register even when load_use_stall=1.
- Undefined: load_use_stall is constant 0, no comparators are built, and the block is a plain stall/flush register.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with ex_RegWrite=1 -> all outputs 0 immediately, before the next clk edge.
- Normal load: id_valid=1, R-type controls (RegDst=1, RegWrite=1, ALUOp=10), id_rd1=0x0000_0005, id_rd2=0x0000_0003, id_rd=8 -> next edge ex_* equal inputs, ex_valid=1.
- Stall: load lw (MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, imm=0x10), then stall=1 for 3 cycles with changing id_* -> ex_* constant with lw values throughout; release -> new instruction loads.
- Flush priority: stall=1 and flush=1 on the same edge with valid sw in ID -> ex_valid=0, ex_MemWrite=0, all control 0.
- Bubble: id_valid=0 with id_RegWrite=1 on the inputs -> ex_valid=0, ex_RegWrite=0.
- Feature (LOAD_USE_DETECT_EN): lw $t1 (rt=9) in EX, add with rs=9 in ID -> load_use_stall=1, next edge ex_valid=0. Following edge, add loads with ex_rs=9. Same sequence with lw rt=0 -> load_use_stall=0.
